// File: rtl/dice_pkg.sv
// Shared types and constants for the N-die roller: FSM states, segment table,
// face advance and sum-width helpers.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Index 0 is the leftmost entry; bit order {A,B,C,D,E,F,G}, active-high.
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  function automatic int sum_width(input int n_dice, input int faces);
    return $clog2(n_dice * faces + 1);
  endfunction

  function automatic logic [3:0] next_face(input logic [3:0] value, input int faces);
    return (value == 4'(faces)) ? 4'd1 : value + 4'd1;
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// Decimal digit to active-high seven-segment pattern {A,B,C,D,E,F,G}.
module seven_seg_dec
  import dice_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b0000000;
    if (i_value <= 4'd9) begin
      o_seg = SEG_TABLE[i_value];
    end
  end

endmodule

// File: rtl/dice_roller_n.sv
// N-die electronic dice: synchronised roll button, prescaled roll ticks,
// decelerating slow-down, doubles buzzer and sum output.
module dice_roller_n
  import dice_pkg::*;
#(
  parameter int N_DICE      = 2,
  parameter int FACES       = 6,
  parameter int TICK_DIV    = 1,
  parameter int SLOW_STEPS  = 4,
  parameter int BUZZ_CYCLES = 16,
  localparam int SUM_W      = sum_width(N_DICE, FACES)
) (
  input  logic                  CLK,
  input  logic                  CLR_n,
  input  logic                  SW,
  output logic [7*N_DICE-1:0]   SEG,
  output logic [4*N_DICE-1:0]   VALUE,
  output logic [SUM_W-1:0]      SUM,
  output logic                  ROLLING,
  output logic                  DONE,
  output logic                  Buzzer
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sw_meta;
  logic             r_sw_s;
  logic             r_sw_d;
  logic             w_rise;
  logic             w_fall;
  logic [PRE_W-1:0] r_presc;
  logic             w_rolling;
  logic             w_tick;
  logic [6:0]       r_slow_cnt;
  logic [2:0]       r_step;
  logic [6:0]       w_gap_last;
  logic             w_enter_roll;
  logic             w_enter_slow;
  logic             w_enter_hold;
  logic             w_slow_step;
  logic             w_all_equal;
  logic [SUM_W-1:0] w_sum;
  logic [4*N_DICE-1:0] w_value;
  logic             r_buzz;
  logic [BUZZ_W-1:0] r_buzz_cnt;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_sw_meta <= 1'b0;
      r_sw_s    <= 1'b0;
      r_sw_d    <= 1'b0;
    end else begin
      r_sw_meta <= SW;
      r_sw_s    <= r_sw_meta;
      r_sw_d    <= r_sw_s;
    end
  end

  assign w_rise     = r_sw_s & ~r_sw_d;
  assign w_fall     = ~r_sw_s & r_sw_d;
  assign w_rolling  = (r_state == ROLL) || (r_state == SLOW);
  assign w_tick     = w_rolling && (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_gap_last = 7'((7'd2 << r_step) - 7'd1);

  always_comb begin
    w_state_next = r_state;
    w_enter_roll = 1'b0;
    w_enter_slow = 1'b0;
    w_enter_hold = 1'b0;
    w_slow_step  = 1'b0;
    case (r_state)
      IDLE: w_enter_roll = w_rise;
      ROLL: w_enter_slow = w_fall;
      SLOW: begin
        // A re-roll pre-empts any step (including the final one) in the same cycle.
        if (w_rise) begin
          w_enter_roll = 1'b1;
        end else if (r_step == 3'(SLOW_STEPS)) begin
          w_enter_hold = 1'b1;
        end else if (w_tick && (r_slow_cnt == w_gap_last)) begin
          w_slow_step = 1'b1;
        end
      end
      HOLD: w_enter_roll = w_rise;
      default: w_state_next = IDLE;
    endcase
    if (w_enter_roll) begin
      w_state_next = ROLL;
    end else if (w_enter_slow) begin
      w_state_next = SLOW;
    end else if (w_enter_hold) begin
      w_state_next = HOLD;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_presc <= '0;
    end else if (w_enter_roll || w_enter_slow) begin
      r_presc <= '0;
    end else if (w_rolling) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // r_slow_cnt counts ticks since the previous step; r_step is the next step index.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_slow_cnt <= '0;
      r_step     <= '0;
    end else if (w_enter_roll || w_enter_slow) begin
      r_slow_cnt <= '0;
      r_step     <= '0;
    end else if (w_slow_step) begin
      r_slow_cnt <= '0;
      r_step     <= r_step + 3'd1;
    end else if ((r_state == SLOW) && w_tick) begin
      r_slow_cnt <= r_slow_cnt + 7'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DICE; gi++) begin : g_die
      logic [3:0] r_val;
      logic [1:0] r_cnt;
      logic       w_roll_adv;

      // Die gi advances on every (gi+1)-th tick while rolling.
      assign w_roll_adv = (r_state == ROLL) && w_tick && (r_cnt == 2'(gi));

      always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
          r_val <= 4'd1;
          r_cnt <= 2'd0;
        end else begin
          if (w_enter_roll) begin
            r_cnt <= 2'd0;
          end else if ((r_state == ROLL) && w_tick) begin
            r_cnt <= (r_cnt == 2'(gi)) ? 2'd0 : r_cnt + 2'd1;
          end
          if (w_roll_adv || w_slow_step) begin
            r_val <= next_face(r_val, FACES);
          end
        end
      end

      assign w_value[4*gi +: 4] = r_val;

      seven_seg_dec u_seg (
        .i_value (r_val),
        .o_seg   (SEG[7*gi +: 7])
      );
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_DICE; i++) begin
      w_sum = w_sum + SUM_W'(w_value[4*i +: 4]);
    end
  end

  always_comb begin
    w_all_equal = (N_DICE >= 2) ? 1'b1 : 1'b0;
    for (int i = 1; i < N_DICE; i++) begin
      if (w_value[4*i +: 4] != w_value[3:0]) begin
        w_all_equal = 1'b0;
      end
    end
  end

  // Values are already frozen on the HOLD-entry edge, so doubles are sampled there.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_enter_roll) begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_enter_hold && w_all_equal && (BUZZ_CYCLES > 0)) begin
      r_buzz     <= 1'b1;
      r_buzz_cnt <= BUZZ_W'(BUZZ_CYCLES - 1);
    end else if (r_buzz) begin
      if (r_buzz_cnt == '0) begin
        r_buzz <= 1'b0;
      end else begin
        r_buzz_cnt <= r_buzz_cnt - 1'b1;
      end
    end
  end

  assign VALUE   = w_value;
  assign SUM     = w_sum;
  assign ROLLING = w_rolling;
  assign DONE    = (r_state == HOLD);
  assign Buzzer  = r_buzz;

endmodule

// File: tb/tb_dice_roller_n.sv
// Self-checking bench for dice_roller_n (default parameters): behavioural model
// compared every cycle, plus directed literal checks and randomized SW activity.
module tb_dice_roller_n;

  localparam int N       = 2;
  localparam int F       = 6;
  localparam int STEPS   = 4;
  localparam int BUZZ    = 16;
  localparam int M_IDLE  = 0;
  localparam int M_ROLL  = 1;
  localparam int M_SLOW  = 2;
  localparam int M_HOLD  = 3;

  logic          CLK   = 1'b0;
  logic          CLR_n = 1'b0;
  logic          SW    = 1'b0;
  logic [13:0]   SEG;
  logic [7:0]    VALUE;
  logic [3:0]    SUM;
  logic          ROLLING;
  logic          DONE;
  logic          Buzzer;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_phase;
  int m_val [N];
  int m_roll_t;
  int m_slow_t;
  int m_steps;
  int m_buzz;
  bit m_sync [3];

  dice_roller_n dut (
    .CLK     (CLK),
    .CLR_n   (CLR_n),
    .SW      (SW),
    .SEG     (SEG),
    .VALUE   (VALUE),
    .SUM     (SUM),
    .ROLLING (ROLLING),
    .DONE    (DONE),
    .Buzzer  (Buzzer)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int adv(input int v);
    return (v == F) ? 1 : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    for (int i = 0; i < N; i++) m_val[i] = 1;
    m_roll_t = 0;
    m_slow_t = 0;
    m_steps  = 0;
    m_buzz   = 0;
    for (int i = 0; i < 3; i++) m_sync[i] = 1'b0;
  endtask

  task automatic model_start_roll();
    m_phase  = M_ROLL;
    m_roll_t = 0;
    m_buzz   = 0;
  endtask

  task automatic model_edge();
    bit rise, fall, eq;
    rise = m_sync[1] && !m_sync[2];
    fall = !m_sync[1] && m_sync[2];
    case (m_phase)
      M_IDLE: if (rise) model_start_roll();
      M_ROLL: begin
        m_roll_t++;
        for (int i = 0; i < N; i++)
          if (m_roll_t % (i + 1) == 0) m_val[i] = adv(m_val[i]);
        if (fall) begin
          m_phase  = M_SLOW;
          m_slow_t = 0;
          m_steps  = 0;
        end
      end
      M_SLOW: begin
        if (rise) begin
          model_start_roll();
        end else if (m_steps == STEPS) begin
          m_phase = M_HOLD;
          eq = 1'b1;
          for (int i = 1; i < N; i++) if (m_val[i] != m_val[0]) eq = 1'b0;
          m_buzz = eq ? BUZZ : 0;
        end else begin
          m_slow_t++;
          // Cumulative tick position of step k is 2+4+...+2^(k+1).
          if (m_slow_t == (1 << (m_steps + 2)) - 2) begin
            for (int i = 0; i < N; i++) m_val[i] = adv(m_val[i]);
            m_steps++;
          end
        end
      end
      M_HOLD: begin
        if (m_buzz > 0) m_buzz--;
        if (rise) model_start_roll();
      end
      default: m_phase = M_IDLE;
    endcase
    m_sync[2] = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = SW;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge CLR_n);
      if (!CLR_n) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [13:0] e_seg;
    logic [7:0]  e_val;
    int          e_sum;
    forever begin
      @(negedge CLK);
      if (CLR_n) begin
        e_seg = '0;
        e_val = '0;
        e_sum = 0;
        for (int i = 0; i < N; i++) begin
          e_seg[7*i +: 7] = seg_of(m_val[i]);
          e_val[4*i +: 4] = 4'(m_val[i]);
          e_sum += m_val[i];
        end
        chk("model_VALUE", int'(VALUE), int'(e_val));
        chk("model_SEG", int'(SEG), int'(e_seg));
        chk("model_SUM", int'(SUM), e_sum);
        chk("model_ROLLING", int'(ROLLING), int'(m_phase == M_ROLL || m_phase == M_SLOW));
        chk("model_DONE", int'(DONE), int'(m_phase == M_HOLD));
        chk("model_Buzzer", int'(Buzzer), int'(m_buzz > 0));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_VALUE"}, int'(VALUE), 8'h11);
    chk({tag, "_SEG"}, int'(SEG), int'({7'b0110000, 7'b0110000}));
    chk({tag, "_SUM"}, int'(SUM), 2);
    chk({tag, "_ROLLING"}, int'(ROLLING), 0);
    chk({tag, "_DONE"}, int'(DONE), 0);
    chk({tag, "_Buzzer"}, int'(Buzzer), 0);
  endtask

  // Async reset pulse strictly between clock edges; called right after a negedge.
  task automatic do_reset();
    #2 CLR_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 CLR_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic roll_for(input int ticks);
    SW = 1'b1;
    cyc(ticks);
    SW = 1'b0;
    cyc(3);
  endtask

  initial begin
    int len;
    // Power-on reset
    cyc(2);
    chk_reset_vals("por");
    CLR_n = 1'b1;
    cyc(5);
    chk_reset_vals("idle");
    $display("[TB] reset/idle checked");

    // Roll: ROLLING rises on the 3rd edge, 7 ticks -> 2,4
    SW = 1'b1;
    cyc(2);
    chk("roll_edge2_ROLLING", int'(ROLLING), 0);
    cyc(1);
    chk("roll_edge3_ROLLING", int'(ROLLING), 1);
    cyc(4);
    SW = 1'b0;
    cyc(3);
    chk("roll7_VALUE", int'(VALUE), 8'h42);
    chk("roll7_SEG", int'(SEG), int'({7'b0110011, 7'b1101101}));
    chk("roll7_SUM", int'(SUM), 6);
    $display("[TB] roll of 7 ticks checked");

    // Slow-down without doubles: steps at +2,+6,+14,+30 ticks
    cyc(1);
    chk("slow_pre_step0", int'(VALUE[3:0]), 2);
    cyc(1);
    chk("slow_step0", int'(VALUE[3:0]), 3);
    cyc(28);
    chk("slow_end_VALUE", int'(VALUE), 8'h26);
    chk("slow_end_DONE", int'(DONE), 0);
    cyc(1);
    chk("hold_DONE", int'(DONE), 1);
    chk("hold_Buzzer", int'(Buzzer), 0);
    $display("[TB] slow-down no doubles checked");

    // Doubles: 12 ticks -> 1,1; slow -> 5,5; buzzer 16 cycles
    do_reset();
    roll_for(12);
    chk("dbl_roll_VALUE", int'(VALUE), 8'h11);
    cyc(30);
    chk("dbl_slow_VALUE", int'(VALUE), 8'h55);
    chk("dbl_slow_SUM", int'(SUM), 10);
    cyc(1);
    chk("dbl_hold_Buzzer", int'(Buzzer), 1);
    cyc(15);
    chk("dbl_buzz_last", int'(Buzzer), 1);
    cyc(1);
    chk("dbl_buzz_off", int'(Buzzer), 0);
    chk("dbl_DONE", int'(DONE), 1);
    $display("[TB] doubles/buzzer checked");

    // Rise coinciding with the final step: ROLL wins, no 4th step
    do_reset();
    roll_for(7);
    cyc(27);
    SW = 1'b1;
    cyc(3);
    chk("final_rise_ROLLING", int'(ROLLING), 1);
    chk("final_rise_DONE", int'(DONE), 0);
    chk("final_rise_VALUE", int'(VALUE), 8'h15);
    SW = 1'b0;
    cyc(50);
    $display("[TB] re-roll on final step checked");

    // Rise during step 2 of SLOW
    do_reset();
    roll_for(7);
    cyc(10);
    SW = 1'b1;
    cyc(3);
    chk("mid_rise_VALUE", int'(VALUE), 8'h64);
    chk("mid_rise_ROLLING", int'(ROLLING), 1);
    cyc(40);
    chk("mid_rise_DONE", int'(DONE), 0);
    chk("mid_rise_Buzzer", int'(Buzzer), 0);
    SW = 1'b0;
    cyc(60);
    $display("[TB] re-roll during slow checked");

    // Async reset mid-SLOW with SW=0, then stay IDLE
    do_reset();
    roll_for(9);
    cyc(8);
    do_reset();
    cyc(5);
    chk_reset_vals("post_rst_idle");
    $display("[TB] async reset mid-slow checked");

    // SW held through reset release starts a new roll
    SW = 1'b1;
    cyc(5);
    do_reset();
    cyc(1);
    chk("held_rst_edge2", int'(ROLLING), 0);
    cyc(1);
    chk("held_rst_edge3", int'(ROLLING), 1);
    SW = 1'b0;
    cyc(50);
    $display("[TB] SW held through reset checked");

    // Randomized SW activity against the model
    for (int t = 0; t < 250; t++) begin
      SW  = ~SW;
      len = $urandom_range(1, 60);
      $display("[TB] rand %0d: SW=%0d for %0d cycles", t, SW, len);
      cyc(len);
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    SW = 1'b0;
    cyc(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
